// File: rtl/de1_blinker_led_out.sv
// Avalon-MM LED output port for the DE1 blinker: plain write, atomic set/clear,
// per-bit blink mask gated by a free-running prescaler phase.
module de1_blinker_led_out #(
    parameter int                WIDTH          = 4,
    parameter logic [WIDTH-1:0]  RESET_VALUE    = '0,
    parameter logic [31:0]       DEFAULT_PERIOD = 32'd24999999
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [2:0]       address,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
    localparam logic [2:0] ADDR_PERIOD   = 3'd2;
    localparam logic [2:0] ADDR_OUTSET   = 3'd3;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd4;
    localparam logic [2:0] ADDR_STATUS   = 3'd5;

    logic [WIDTH-1:0] data, data_next;
    logic [WIDTH-1:0] blink_en, blink_en_next;
    logic [31:0]      period, period_next;
    logic [31:0]      cnt, cnt_next;
    logic             phase, phase_next;
    logic [31:0]      read_value;
    logic             wr_en;
    logic [WIDTH-1:0] wdata;

    assign wr_en = chipselect & ~write_n;
    assign wdata = writedata[WIDTH-1:0];

    always_comb begin
        data_next     = data;
        blink_en_next = blink_en;
        period_next   = period;
        if (wr_en) begin
            case (address)
                ADDR_DATA:     data_next     = wdata;
                ADDR_BLINK_EN: blink_en_next = wdata;
                ADDR_PERIOD:   period_next   = writedata;
                ADDR_OUTSET:   data_next     = data | wdata;
                ADDR_OUTCLEAR: data_next     = data & ~wdata;
                default:       ;
            endcase
        end
    end

    // A PERIOD write restarts the blink cycle and wins over a coincident wrap.
    always_comb begin
        cnt_next   = cnt + 32'd1;
        phase_next = phase;
        if (wr_en && (address == ADDR_PERIOD)) begin
            cnt_next   = '0;
            phase_next = 1'b0;
        end else if (cnt >= period) begin
            cnt_next   = '0;
            phase_next = ~phase;
        end
    end

    always_comb begin
        read_value = '0;
        case (address)
            ADDR_DATA:     read_value[WIDTH-1:0] = data;
            ADDR_BLINK_EN: read_value[WIDTH-1:0] = blink_en;
            ADDR_PERIOD:   read_value            = period;
            ADDR_STATUS:   read_value[0]         = phase;
            default:       read_value            = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data     <= RESET_VALUE;
            blink_en <= '0;
            period   <= DEFAULT_PERIOD;
            cnt      <= '0;
            phase    <= 1'b0;
            out_port <= RESET_VALUE;
            readdata <= '0;
        end else begin
            data     <= data_next;
            blink_en <= blink_en_next;
            period   <= period_next;
            cnt      <= cnt_next;
            phase    <= phase_next;
            out_port <= data_next & ~(blink_en_next & {WIDTH{phase_next}});
            readdata <= read_value;
        end
    end

endmodule

// File: tb/tb_de1_blinker_led_out.sv
// Directed plus randomized bench for de1_blinker_led_out, checked against a
// register-level behavioural model of the LED port.
module tb_de1_blinker_led_out;

    localparam int          WIDTH   = 4;
    localparam logic [3:0]  RST_VAL = 4'b1010;
    localparam logic [31:0] DEF_PER = 32'd9;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        chipselect;
    logic        write_n;
    logic [2:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  out_port;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model of the register file and blink phase
    logic [3:0]  m_data, m_blink;
    logic [31:0] m_period, m_cnt, m_rd;
    logic        m_phase;
    logic [3:0]  m_out;

    de1_blinker_led_out #(
        .WIDTH(WIDTH), .RESET_VALUE(RST_VAL), .DEFAULT_PERIOD(DEF_PER)
    ) dut (
        .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .write_n(write_n),
        .address(address), .writedata(writedata), .readdata(readdata), .out_port(out_port)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_data = RST_VAL; m_blink = '0; m_period = DEF_PER;
        m_cnt = '0; m_phase = 1'b0; m_out = RST_VAL; m_rd = '0;
    endtask

    // One bus cycle: drive, advance the model by one clock, compare #1 after the edge.
    task automatic step(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] wd);
        logic        wr;
        logic [31:0] rd, n_period, n_cnt;
        logic [3:0]  n_data, n_blink;
        logic        n_phase;
        chipselect = cs; write_n = wn; address = a; writedata = wd;
        wr = cs && !wn;
        case (a)
            3'd0:    rd = {28'd0, m_data};
            3'd1:    rd = {28'd0, m_blink};
            3'd2:    rd = m_period;
            3'd5:    rd = {31'd0, m_phase};
            default: rd = 32'd0;
        endcase
        n_data = m_data; n_blink = m_blink; n_period = m_period;
        if (wr) begin
            if (a == 3'd0) n_data = wd[3:0];
            if (a == 3'd1) n_blink = wd[3:0];
            if (a == 3'd2) n_period = wd;
            if (a == 3'd3) n_data = m_data | wd[3:0];
            if (a == 3'd4) n_data = m_data & ~wd[3:0];
        end
        if (wr && a == 3'd2) begin
            n_cnt = 0; n_phase = 1'b0;
        end else if (m_cnt >= m_period) begin
            n_cnt = 0; n_phase = !m_phase;
        end else begin
            n_cnt = m_cnt + 1; n_phase = m_phase;
        end
        @(posedge clk);
        m_data = n_data; m_blink = n_blink; m_period = n_period;
        m_cnt = n_cnt; m_phase = n_phase; m_rd = rd;
        m_out = n_data & ~(n_blink & {4{n_phase}});
        #1;
        check("out_port", {28'd0, out_port}, {28'd0, m_out});
        check("readdata", readdata, m_rd);
    endtask

    initial begin
        int zeros;
        int edges;
        logic [2:0] ra;
        logic [31:0] rw;

        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
        model_reset();
        #12;
        check("reset_out_port", {28'd0, out_port}, 32'h0000_000A);
        check("reset_readdata", readdata, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        step(1'b0, 1'b1, 3'd0, 32'h0);
        check("read_data_after_reset", readdata, 32'h0000_000A);

        step(1'b1, 1'b0, 3'd0, 32'h5);
        check("write_data", {28'd0, out_port}, 32'h5);
        step(1'b1, 1'b0, 3'd3, 32'h2);
        check("outset", {28'd0, out_port}, 32'h7);
        step(1'b1, 1'b0, 3'd4, 32'h4);
        check("outclear", {28'd0, out_port}, 32'h3);
        step(1'b0, 1'b1, 3'd3, 32'h0);
        check("read_outset", readdata, 32'h0);
        step(1'b0, 1'b1, 3'd4, 32'h0);
        check("read_outclear", readdata, 32'h0);

        step(1'b0, 1'b0, 3'd0, 32'hF);
        check("no_chipselect", {28'd0, out_port}, 32'h3);
        step(1'b1, 1'b0, 3'd6, 32'hF);
        check("reserved_write", {28'd0, out_port}, 32'h3);
        step(1'b1, 1'b0, 3'd0, 32'hFFFF_FFFF);
        step(1'b0, 1'b1, 3'd0, 32'h0);
        check("wide_write_masked", readdata, 32'h0000_000F);

        step(1'b1, 1'b0, 3'd2, 32'd3);
        step(1'b1, 1'b0, 3'd1, 32'hF);
        step(1'b1, 1'b0, 3'd0, 32'hF);
        zeros = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 3'd5, 32'h0);
            if (out_port == 4'h0) zeros++;
        end
        check("blink_half_duty", zeros, 32'd8);

        for (int i = 0; i < 10 && m_cnt != 32'd3; i++) step(1'b0, 1'b1, 3'd5, 32'h0);
        check("reach_wrap_cycle", m_cnt, 32'd3);
        step(1'b1, 1'b0, 3'd2, 32'd3);
        check("period_write_beats_wrap", {28'd0, out_port}, 32'hF);
        edges = 0;
        for (int i = 0; i < 20 && out_port != 4'h0; i++) begin
            step(1'b0, 1'b1, 3'd5, 32'h0);
            edges++;
        end
        check("toggle_after_reload", edges, 32'd4);

        for (int i = 0; i < 10 && !m_phase; i++) step(1'b0, 1'b1, 3'd5, 32'h0);
        check("phase_high_before_reset", {31'd0, m_phase}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_out_port", {28'd0, out_port}, 32'h0000_000A);
        check("async_reset_readdata", readdata, 32'h0);
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;

        edges = 0;
        for (int i = 0; i < 50 && readdata[0] !== 1'b1; i++) begin
            step(1'b0, 1'b1, 3'd5, 32'h0);
            edges++;
        end
        check("first_toggle_after_reset", edges, DEF_PER + 32'd2);

        for (int i = 0; i < 300; i++) begin
            ra = 3'($urandom_range(0, 7));
            rw = $urandom;
            if (ra == 3'd2) rw = $urandom_range(0, 5);
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rw);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
